uart_rx: RTL and testbench

UART receiver for the SoC's serial console input. It recovers 8N1 frames from the board's asynchronous RsRx pin using 16x oversampling, buffers the bytes in a small FIFO, and presents them on a valid/ready read port. The port is consumed by the future UART peripheral on the AXI4-Lite crossbar. The block runs entirely in the core clock domain (40 MHz default).

---
 rtl/uart_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with 16x oversampling, 2-flop input
//                synchronizer, glitch rejection, break suppression and a
//                small receive FIFO exposed on a valid/ready read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ   = 40_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Clock cycles per oversampling tick, rounded to nearest.
    localparam int TICK_DIV = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
    localparam int DIV_W    = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    generate
        if (TICK_DIV < 2) begin : g_bad_tick_div
            $error("uart_rx: TICK_DIV must be at least 2 (CLK_FREQ too low for BAUD)");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_rx: FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t       state;
    state_t       state_nx;

    logic         sync1;
    logic         rx_s;
    logic         armed;
    logic [DIV_W-1:0] div_cnt;
    logic         tick;
    logic [3:0]   tcnt;
    logic [2:0]   bidx;
    logic [7:0]   shreg;

    // FSM strobes
    logic         start_enter;
    logic         start_ok;
    logic         bit_sample;
    logic         stop_sample;

    // FIFO
    logic [7:0]   mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  wr_ptr_nx;
    logic [AW:0]  rd_ptr_nx;
    logic         fifo_full;
    logic         pop;
    logic         room;
    logic         push;
    logic [7:0]   head_nx;

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    // Oversampling divider, realigned to the start edge so sampling is centred.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (start_enter || (div_cnt == DIV_LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and single-cycle datapath strobes.
    always_comb begin
        state_nx    = state;
        start_enter = 1'b0;
        start_ok    = 1'b0;
        bit_sample  = 1'b0;
        stop_sample = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    state_nx    = START;
                    start_enter = 1'b1;
                end
            end
            START: begin
                // Mid start bit: a high line here was only a glitch.
                if (tick && (tcnt == 4'd7)) begin
                    if (rx_s) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = DATA;
                        start_ok = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick && (tcnt == 4'd15)) begin
                    bit_sample = 1'b1;
                    if (bidx == 3'd7) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                // Returning to IDLE mid stop bit leaves half a bit of margin
                // for a back-to-back start edge.
                if (tick && (tcnt == 4'd15)) begin
                    stop_sample = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Tick counter within the current bit, cleared at start entry and data entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= 4'd0;
        end else if (start_enter || start_ok) begin
            tcnt <= 4'd0;
        end else if (tick) begin
            tcnt <= tcnt + 4'd1;
        end
    end

    // Data bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bidx  <= 3'd0;
            shreg <= 8'h00;
        end else if (start_ok) begin
            bidx  <= 3'd0;
        end else if (bit_sample) begin
            bidx  <= bidx + 3'd1;
            shreg <= {rx_s, shreg[7:1]};
        end
    end

    // Armed once the line is seen high; a framing error disarms so a held
    // break does not retrigger reception.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (stop_sample && !rx_s) begin
            armed <= 1'b0;
        end else if (rx_s) begin
            armed <= 1'b1;
        end
    end

    assign busy = (state != IDLE);

    // FIFO control: a same-cycle pop frees a slot for the incoming byte.
    assign pop       = rd_valid && rd_ready;
    assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign room      = !fifo_full || pop;
    assign push      = stop_sample && rx_s && room;
    assign wr_ptr_nx = push ? (wr_ptr + PTR_ONE) : wr_ptr;
    assign rd_ptr_nx = pop  ? (rd_ptr + PTR_ONE) : rd_ptr;

    // A push lands on the next head slot only when the FIFO is empty after
    // the pop, so the incoming byte is forwarded straight to the head register.
    assign head_nx = (push && (wr_ptr[AW-1:0] == rd_ptr_nx[AW-1:0])) ?
                     shreg : mem[rd_ptr_nx[AW-1:0]];

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= shreg;
        end
    end

    // Pointers, registered read port and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= 8'h00;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nx;
            rd_ptr    <= rd_ptr_nx;
            rd_valid  <= (wr_ptr_nx != rd_ptr_nx);
            rd_data   <= head_nx;
            frame_err <= stop_sample && !rx_s;
            overrun   <= stop_sample && rx_s && !room;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx (TICK_DIV=2, 32 clocks/bit)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int DEPTH    = 8;
    localparam int BIT_CLKS = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(
        .CLK_FREQ   (3_200_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int valid_cycles = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bclk;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    // Expected outcome is recorded when the frame is launched.
    task automatic send_byte(input logic [7:0] data, input logic stop_val,
                             input int bclk, input bit model);
        if (model) begin
            if (stop_val) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(data);
                else exp_ov++;
            end else begin
                exp_fe++;
            end
        end
        drive_bit(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive_bit(data[i], bclk);
        drive_bit(stop_val, bclk);
    endtask

    // Output monitor: scoreboard compare on each accepted byte, pulse counters.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            if (rd_valid)  valid_cycles++;
            if (rd_valid && rd_ready) begin
                if (exp_q.size() > 0) check("popped byte", rd_data, exp_q.pop_front());
                else check("scoreboard nonempty at pop", exp_q.size(), 1);
            end
        end
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    int v0;
    int fe0;
    bit seen;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, BIT_CLKS};
        vecs[1] = '{8'h5A, 1'b1, 31};
        vecs[2] = '{8'hC3, 1'b1, 33};
        vecs[3] = '{8'h12, 1'b0, BIT_CLKS};
        vecs[4] = '{8'h96, 1'b1, BIT_CLKS};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rd_valid", rd_valid, 0);
        check("reset rd_data", rd_data, 8'h00);
        check("reset frame_err", frame_err, 0);
        check("reset overrun", overrun, 0);
        check("reset busy", busy, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        idle(64);

        // Table-driven single frames with rd_ready=1
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            v0 = valid_cycles;
            send_byte(vecs[i].data, vecs[i].stop, vecs[i].bclk, 1'b1);
            idle(64);
            check("vec rd_valid cycles", valid_cycles - v0, vecs[i].stop ? 1 : 0);
            check("vec frame_err count", fe_cnt, exp_fe);
            check("vec overrun count", ov_cnt, exp_ov);
            check("vec scoreboard drained", exp_q.size(), 0);
        end

        // Back-to-back frames, zero idle bits, held in the FIFO
        rd_ready = 1'b0;
        send_byte(8'h00, 1'b1, BIT_CLKS, 1'b1);
        send_byte(8'hFF, 1'b1, BIT_CLKS, 1'b1);
        send_byte(8'h55, 1'b1, BIT_CLKS, 1'b1);
        idle(8);
        @(negedge clk);
        check("b2b head valid", rd_valid, 1);
        check("b2b head data", rd_data, 8'h00);
        @(posedge clk); #2;
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b consecutive valid", rd_valid, 1);
        end
        @(negedge clk);
        check("b2b empty after drain", rd_valid, 0);
        check("b2b scoreboard drained", exp_q.size(), 0);
        idle(16);

        // Short glitch while idle
        v0 = valid_cycles;
        rx = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("glitch busy seen", seen, 1);
        check("glitch busy cleared", busy, 0);
        check("glitch no push", valid_cycles - v0, 0);
        check("glitch frame_err count", fe_cnt, exp_fe);
        idle(16);

        // Framing error followed by a long break, then a good frame
        fe0 = fe_cnt;
        send_byte(8'h3C, 1'b0, BIT_CLKS, 1'b1);
        drive_bit(1'b0, 20 * BIT_CLKS);
        idle(64);
        send_byte(8'h81, 1'b1, BIT_CLKS, 1'b1);
        idle(64);
        check("break single frame_err", fe_cnt - fe0, 1);
        check("break frame_err count", fe_cnt, exp_fe);
        check("break scoreboard drained", exp_q.size(), 0);

        // Overrun: nine bytes into an eight-entry FIFO
        rd_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, BIT_CLKS, 1'b1);
        idle(16);
        check("overrun count", ov_cnt, exp_ov);
        check("overrun full head", rd_data, 8'h01);
        @(posedge clk); #2;
        rd_ready = 1'b1;
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) @(negedge clk);
        check("overrun drain complete", exp_q.size(), 0);
        idle(16);

        // Reset during data bit 4, then a clean frame
        fork
            send_byte(8'hF5, 1'b1, BIT_CLKS, 1'b0);
            begin
                repeat (5 * BIT_CLKS + 16) @(posedge clk);
                #2;
                rst = 1'b1;
                @(posedge clk); #2;
                rst = 1'b0;
                @(negedge clk);
                check("midrst busy", busy, 0);
                check("midrst rd_valid", rd_valid, 0);
                check("midrst rd_data", rd_data, 8'h00);
                check("midrst frame_err", frame_err, 0);
                check("midrst overrun", overrun, 0);
            end
        join
        idle(64);
        send_byte(8'h7E, 1'b1, BIT_CLKS, 1'b1);
        idle(64);
        check("post-reset frame_err count", fe_cnt, exp_fe);
        check("post-reset overrun count", ov_cnt, exp_ov);
        check("final scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
